md_issue_ctrl: RTL

- Issue controller directly upstream of the multiply/divide unit, sitting in the E stage.
- Accepts mult/multu/div/divu/mthi/mtlo requests from the E-stage instruction and holds one in a single-entry pending buffer when the unit is busy.
- Drives a registered one-cycle start pulse with op and operands into the multiply/divide unit, and mirrors its busy countdown.
- Generates the E-stage stall for back-to-back MD ops and for mfhi/mflo reads while results are outstanding.

---
 rtl/md_issue_if.sv | 24 ++
 rtl/md_issue_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/md_issue_if.sv
// E-stage to multiply/divide issue path: request side from E, start side to the MD unit.
interface md_issue_if;
  logic        int_req;
  logic        e_md_valid;
  logic [2:0]  e_md_op;
  logic        e_md_read;
  logic [31:0] e_src1;
  logic [31:0] e_src2;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_src1;
  logic [31:0] md_src2;
  logic        stall_e;
  logic        md_busy;

  modport master (
    output int_req, e_md_valid, e_md_op, e_md_read, e_src1, e_src2,
    input  md_start, md_op, md_src1, md_src2, stall_e, md_busy
  );
  modport slave (
    input  int_req, e_md_valid, e_md_op, e_md_read, e_src1, e_src2,
    output md_start, md_op, md_src1, md_src2, stall_e, md_busy
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// Multiply/divide issue controller: single-entry pending buffer, start pulse,
// busy countdown mirror and E-stage stall generation.
module md_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_issue_if.slave md
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic          start_q;
  logic [2:0]    op_q;
  logic [31:0]   src1_q, src2_q;
  logic [CW-1:0] cnt;
  logic          pend_v;
  logic [2:0]    pend_op;
  logic [31:0]   pend_a, pend_b;

  logic          valid_op, issue_ok, accept, issue;
  logic [2:0]    sel_op;
  logic [31:0]   sel_a, sel_b;

  function automatic logic [CW-1:0] busy_cycles(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: busy_cycles = CW'(MULT_CYCLES);
      3'd2, 3'd3: busy_cycles = CW'(DIV_CYCLES);
      default:    busy_cycles = '0;
    endcase
  endfunction

  // Ops 6/7 behave as if no MD write op were present.
  assign valid_op = md.e_md_valid & (md.e_md_op < 3'd6);
  assign issue_ok = (cnt == '0) & ~start_q & ~md.int_req;

  assign md.stall_e = ~md.int_req &
                      ((valid_op & pend_v & ~issue_ok) |
                       (md.e_md_read & ((cnt != '0) | start_q | pend_v)));
  assign accept = valid_op & ~md.stall_e & ~md.int_req;

  // The pending entry is always older than the E op, so it issues first.
  assign issue  = issue_ok & (pend_v | accept);
  assign sel_op = pend_v ? pend_op : md.e_md_op;
  assign sel_a  = pend_v ? pend_a  : md.e_src1;
  assign sel_b  = pend_v ? pend_b  : md.e_src2;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= 1'b0;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      cnt     <= '0;
      pend_v  <= 1'b0;
      pend_op <= '0;
      pend_a  <= '0;
      pend_b  <= '0;
    end else begin
      if (issue) begin
        start_q <= 1'b1;
        op_q    <= sel_op;
        src1_q  <= sel_a;
        src2_q  <= sel_b;
        cnt     <= busy_cycles(sel_op);
      end else begin
        start_q <= 1'b0;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end

      if (md.int_req) begin
        pend_v <= 1'b0;
      end else if (accept & (pend_v | ~issue_ok)) begin
        // Either refill behind a draining entry or capture while the unit is busy.
        pend_v  <= 1'b1;
        pend_op <= md.e_md_op;
        pend_a  <= md.e_src1;
        pend_b  <= md.e_src2;
      end else if (pend_v & issue_ok) begin
        pend_v <= 1'b0;
      end
    end
  end

  assign md.md_start = start_q;
  assign md.md_op    = op_q;
  assign md.md_src1  = src1_q;
  assign md.md_src2  = src2_q;
  assign md.md_busy  = (cnt != '0) | start_q | pend_v;
endmodule
